// File: rtl/ff_step_pkg.sv
// rtl/ff_step_pkg.sv - shared FSM encoding and default timing constants for the step controller
package ff_step_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      FIRE         = 2'd1,
      WAIT_RELEASE = 2'd2
   } state_t;

   // 10 ms debounce and 0.5 s auto-step period at 100 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEFAULT_AUTO_DIV        = 50_000_000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer followed by a consecutive-sample debounce counter
module btn_debounce
   import ff_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic Clk,
   input  logic notRst,
   input  logic raw,
   output logic stable
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

   logic sync1;
   logic sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge Clk or negedge notRst) begin
      if (!notRst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         // any sample matching the current level restarts the qualification window
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == LIMIT) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ff_step_controller.sv
// rtl/ff_step_controller.sv - one clean ff_ce pulse per debounced press; AUTO_STEP_EN adds divided auto-stepping
module ff_step_controller
   import ff_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
`ifdef AUTO_STEP_EN
   parameter int AUTO_DIV        = DEFAULT_AUTO_DIV,
`endif
   parameter int CNT_W           = 8
) (
   input  logic             Clk,
   input  logic             notRst,
   input  logic             btn,
   input  logic             hold,
`ifdef AUTO_STEP_EN
   input  logic             auto_mode,
`endif
   output logic             ff_ce,
   output logic [CNT_W-1:0] step_count,
   output logic             busy,
   output logic [1:0]       state
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_FIRE = FIRE;
   localparam logic [1:0] S_WAIT = WAIT_RELEASE;

   logic       stable;
   logic       stable_q;
   logic       press;
   logic       tick;
   logic [1:0] state_next;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .Clk   (Clk),
      .notRst(notRst),
      .raw   (btn),
      .stable(stable)
   );

   assign press = stable & ~stable_q;

`ifdef AUTO_STEP_EN
   localparam int DW = $clog2(AUTO_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(AUTO_DIV - 1);

   logic [DW-1:0] div;
   logic          div_run;

   assign div_run = auto_mode & ~hold & (state == S_IDLE);
   assign tick    = div_run & (div == DIV_LAST);

   always_ff @(posedge Clk or negedge notRst) begin
      if (!notRst) begin
         div <= '0;
      end else if (!div_run || tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end
`else
   assign tick = 1'b0;
`endif

   // a press seen while held or busy is dropped, never queued
   always_comb begin
      state_next = S_IDLE;
      case (state)
         S_IDLE:  state_next = ((press && !hold) || tick) ? S_FIRE : S_IDLE;
         S_FIRE:  state_next = stable ? S_WAIT : S_IDLE;
         S_WAIT:  state_next = stable ? S_WAIT : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge notRst) begin
      if (!notRst) begin
         state      <= S_IDLE;
         stable_q   <= 1'b0;
         ff_ce      <= 1'b0;
         step_count <= '0;
      end else begin
         state    <= state_next;
         stable_q <= stable;
         ff_ce    <= (state_next == S_FIRE);
         if (state == S_FIRE) begin
            step_count <= step_count + 1'b1;
         end
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ff_step_controller.sv
// tb/tb_ff_step_controller.sv - directed self-checking bench for ff_step_controller
module tb_ff_step_controller;

   logic       Clk    = 1'b0;
   logic       notRst = 1'b0;
   logic       btn    = 1'b0;
   logic       hold   = 1'b0;
`ifdef AUTO_STEP_EN
   logic       auto_mode = 1'b0;
`endif
   logic       ff_ce;
   logic [7:0] step_count;
   logic       busy;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pulses = 0;
   int b2b    = 0;
   logic prev_ce = 1'b0;

   ff_step_controller #(
      .DEBOUNCE_CYCLES(4),
`ifdef AUTO_STEP_EN
      .AUTO_DIV       (8),
`endif
      .CNT_W          (8)
   ) dut (
      .Clk       (Clk),
      .notRst    (notRst),
      .btn       (btn),
      .hold      (hold),
`ifdef AUTO_STEP_EN
      .auto_mode (auto_mode),
`endif
      .ff_ce     (ff_ce),
      .step_count(step_count),
      .busy      (busy),
      .state     (state)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc++;

   always @(negedge Clk) begin
      if (ff_ce === 1'b1) begin
         pulses++;
         if (prev_ce === 1'b1) b2b++;
      end
      prev_ce = ff_ce;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge Clk);
         #1;
      end
   endtask

   task automatic do_reset();
      notRst = 1'b0;
      btn    = 1'b0;
      hold   = 1'b0;
`ifdef AUTO_STEP_EN
      auto_mode = 1'b0;
`endif
      step(3);
      notRst = 1'b1;
      step(1);
   endtask

   task automatic press(input int high, input int low);
      btn = 1'b1;
      step(high);
      btn = 1'b0;
      step(low);
   endtask

   int p0;
   int c0;
   int lat;
   int seen;
   int busy_mid;
   int state_mid;
   int stamps[$];

   initial begin
      // reset state
      step(2);
      check("rst_ff_ce", int'(ff_ce), 0);
      check("rst_step_count", int'(step_count), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_state", int'(state), 0);
      notRst = 1'b1;
      step(1);

      // clean press
      do_reset();
      p0 = pulses;
      c0 = cyc;
      lat = -1;
      btn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (ff_ce === 1'b1 && lat < 0) lat = cyc - c0 - 1;
         if (i == 15) begin
            busy_mid  = int'(busy);
            state_mid = int'(state);
         end
      end
      btn = 1'b0;
      step(12);
      check("clean_pulses", pulses - p0, 1);
      check("clean_latency_window", int'(lat >= 6 && lat <= 8), 1);
      check("clean_step_count", int'(step_count), 1);
      check("clean_busy_held", busy_mid, 1);
      check("clean_state_held", state_mid, 2);
      check("clean_busy_released", int'(busy), 0);
      check("clean_state_released", int'(state), 0);

      // async reset in the middle of FIRE, then a press held across reset release
      do_reset();
      press(12, 12);
      btn = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         step(1);
         if (ff_ce === 1'b1) seen = 1;
      end
      check("midfire_seen", seen, 1);
      notRst = 1'b0;
      #1;
      check("midfire_rst_ff_ce", int'(ff_ce), 0);
      check("midfire_rst_step_count", int'(step_count), 0);
      check("midfire_rst_state", int'(state), 0);
      check("midfire_rst_busy", int'(busy), 0);
      step(2);
      p0 = pulses;
      notRst = 1'b1;
      step(15);
      btn = 1'b0;
      step(12);
      check("held_across_rst_pulses", pulses - p0, 1);
      check("held_across_rst_count", int'(step_count), 1);

      // bounce shorter than the debounce window
      do_reset();
      p0 = pulses;
      for (int i = 0; i < 3; i++) begin
         btn = 1'b1;
         step(2);
         btn = 1'b0;
         step(2);
      end
      step(20);
      check("bounce_pulses", pulses - p0, 0);
      check("bounce_step_count", int'(step_count), 0);
      check("bounce_state", int'(state), 0);

      // hold suppresses a press; hold raised during WAIT_RELEASE is ignored
      do_reset();
      p0 = pulses;
      hold = 1'b1;
      press(20, 12);
      check("hold_pulses", pulses - p0, 0);
      check("hold_state", int'(state), 0);
      hold = 1'b0;
      btn = 1'b1;
      step(12);
      hold = 1'b1;
      step(4);
      btn = 1'b0;
      step(12);
      check("hold_after_pulses", pulses - p0, 1);
      check("hold_after_count", int'(step_count), 1);
      check("hold_after_state", int'(state), 0);
      hold = 1'b0;

      // step counter wrap
      do_reset();
      p0 = pulses;
      repeat (255) press(10, 10);
      check("wrap_count_255", int'(step_count), 255);
      press(10, 10);
      check("wrap_count_0", int'(step_count), 0);
      check("wrap_pulses", pulses - p0, 256);

`ifdef AUTO_STEP_EN
      // free-running auto steps: 8 idle divider cycles plus the FIRE cycle
      do_reset();
      c0 = cyc;
      stamps.delete();
      auto_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (ff_ce === 1'b1) stamps.push_back(cyc);
      end
      auto_mode = 1'b0;
      step(2);
      check("auto_pulse_count", stamps.size(), 4);
      if (stamps.size() > 0) check("auto_first_offset", stamps[0] - c0, 8);
      for (int i = 1; i < stamps.size(); i++) begin
         check("auto_gap", stamps[i] - stamps[i-1], 9);
      end

      // divider tick landing on the same edge as a debounced press
      do_reset();
      p0 = pulses;
      c0 = cyc;
      lat = -1;
      btn = 1'b1;
      auto_mode = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (ff_ce === 1'b1 && lat < 0) lat = cyc - c0;
      end
      auto_mode = 1'b0;
      btn = 1'b0;
      step(12);
      check("coincide_edge", lat, 8);
      check("coincide_pulses", pulses - p0, 1);
      check("coincide_count", int'(step_count), 1);
`endif

      check("no_back_to_back", b2b, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout observed %0d expected %0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ff_step_controller.md
# ff_step_controller

Sequencer that drives the shared clock-enable of the lab flip-flop bank (D, JK and T cells). It turns a raw push-button into exactly one clean, single-cycle step pulse per press. It can optionally auto-step at a fixed divided rate. It sits between the board button and the flip-flop bank, so every flip-flop updates on a free-running system clock instead of a bouncing button edge.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive equal synchronized samples required before the debounced level changes (10 ms at 100 MHz).
- AUTO_DIV, 50_000_000: auto-step period in Clk cycles, ≥2.
- CNT_W, 8: width of step counter.

- Clk  in  1  system clock; all state on rising edge.
- notRst  in  1  asynchronous, active-low reset.
- btn  in  1  raw, asynchronous, bouncing button.
- hold  in  1  synchronous; when 1, no step pulses are issued.
- auto_mode  in  1  selects auto-stepping. The port is present only with AUTO_STEP_EN.
- ff_ce  out  1  single-cycle clock-enable to the flip-flop bank.
- step_count  out  CNT_W  number of pulses issued, modulo 2^CNT_W.
- busy  out  1  FSM not in IDLE.
- state  out  2  current FSM state, for debug.

## Operation
- btn passes through a 2-flop synchronizer, then a debounce counter.
  - The counter clears whenever the synchronized value equals the stable level.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level takes the synchronized value and the counter clears.
- FSM states: IDLE=0, FIRE=1, WAIT_RELEASE=2 (3 unused; it transitions to IDLE).
- IDLE -> FIRE: stable level rising edge and hold=0.
- IDLE, press with hold=1: the edge is discarded, not queued. The FSM stays in IDLE; the release is absorbed.
- FIRE, single cycle:
  - ff_ce=1 and step_count increments, wrapping 2^CNT_W-1 -> 0.
  - Next state is WAIT_RELEASE if the stable level is 1, else IDLE.
- WAIT_RELEASE -> IDLE when the stable level is 0. No further pulses while held.
- hold rising while in WAIT_RELEASE has no effect on the transition.
- busy = (state != IDLE).
- Reset (notRst=0), effective immediately:
  - ff_ce=0, step_count=0, busy=0, state=IDLE.
  - Synchronizer, stable level, debounce counter and divider all 0.
  - A press held across reset release is treated as a fresh press once debounced.

## Timing
- Manual latency: btn sampled high at edge 0 -> ff_ce high in the cycle following edge DEBOUNCE_CYCLES+3. That is 2 sync + DEBOUNCE_CYCLES + 1 FSM, with ±1 cycle for asynchronous capture.
- ff_ce is exactly one Clk cycle wide and is never asserted on two consecutive cycles.
- Bounce shorter than DEBOUNCE_CYCLES cycles produces no pulse and does not alter the stable level.
- ff_ce and step_count are registered outputs. step_count changes on the same edge that ends the FIRE cycle's ff_ce.

## Configuration
- AUTO_STEP_EN defined:
  - auto_mode port exists.
  - In IDLE with auto_mode=1 and hold=0, the divider counts 0..AUTO_DIV-1. At terminal count the FSM goes to FIRE and the divider clears.
  - The divider clears whenever auto_mode=0, hold=1, or state != IDLE.
  - A divider tick coinciding with a debounced press yields one pulse only.
  - From FIRE in auto mode the FSM follows the same next-state rule as manual mode.
- AUTO_STEP_EN undefined: no auto_mode port, no divider logic; manual stepping only.

## Structure
- Package ff_step_pkg holds:
  - typedef state_t: IDLE, FIRE, WAIT_RELEASE.
  - Shared default constants for DEBOUNCE_CYCLES and AUTO_DIV.
- Sub-module btn_debounce contains the synchronizer and debounce counter.
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: Clk, notRst, raw in, stable out.
- The FSM, step counter and divider live in ff_step_controller.

## Test plan
All cases use DEBOUNCE_CYCLES=4, AUTO_DIV=8, CNT_W=8.
- Reset: notRst=0 mid-FIRE -> ff_ce=0, step_count=0, state=0 immediately, with no clock.
- Clean press: btn held 20 cycles -> exactly one ff_ce pulse, 7±1 cycles after btn rise; step_count=1; busy high until stable goes low.
- Bounce: btn toggles every 2 cycles for 12 cycles, then stays low -> no ff_ce; step_count=0.
- Hold: press with hold=1 -> no pulse. Release, drop hold, press again -> one pulse, step_count=1.
- Wrap: 256 clean presses -> step_count=0, 256 total ff_ce pulses counted.
- Auto (AUTO_STEP_EN): auto_mode=1 for 40 cycles -> ff_ce every 9 cycles (8 divider + FIRE), with no gap of 1. A press coinciding with a tick gives one pulse. Without the macro, the bench builds with manual stepping only.
